// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-to-read bypass and a per-register pending scoreboard.
// Register 0 and out-of-range addresses read as zero, are never busy, and ignore writes and claims.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic                   claim,
  input  logic [AW-1:0]          ca,
  output logic [AW:0]            npend
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      npend_q, npend_d;
  logic             wr_ok, cl_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < 32'(NREGS));
  endfunction

  assign wr_ok = we && addr_ok(wa);
  assign cl_ok = claim && addr_ok(ca);

  // Claim is applied after the write clear so a same-cycle claim from the newer producer wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) pend_d[wa] = 1'b0;
    if (cl_ok) pend_d[ca] = 1'b1;
    npend_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      npend_d = npend_d + (AW+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      npend_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      npend_q <= npend_d;
      if (wr_ok) mem_q[wa] <= wd;
    end
  end

  assign npend = npend_q;

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          ok, byp;
    assign a   = ra[g*AW +: AW];
    assign ok  = addr_ok(a);
    assign byp = we && (wa == a);
    assign rd[g*WIDTH +: WIDTH] = !ok ? '0 : (byp ? wd : mem_q[a]);
    assign rbusy[g]             = ok && !byp && pend_q[a];
  end

endmodule
